// File: rtl/idu_stage.sv
// Registered RV64I decode stage: instruction FIFO, head decoder, RAW/WAW scoreboard, decoded-output register.
// Optional macro IDU_MEXT_EN makes the M-extension OP/OP-32 encodings legal.
module idu_stage #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned IBUF_DEPTH = 4,
  parameter int unsigned NREG       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rf_we,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_is_branch,
  output logic            out_is_csr,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);
  localparam int unsigned PW = $clog2(IBUF_DEPTH);
  localparam int unsigned CW = PW + 1;
`ifdef IDU_MEXT_EN
  localparam bit MEXT_EN = 1'b1;
`else
  localparam bit MEXT_EN = 1'b0;
`endif

  logic [31:0]     buf_instr_q [IBUF_DEPTH];
  logic [XLEN-1:0] buf_pc_q    [IBUF_DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_imm_q;
  logic [4:0]      out_rs1_q, out_rs2_q, out_rd_q;
  logic            out_rf_we_q, out_ld_q, out_st_q, out_br_q, out_csr_q, out_ill_q;

  logic [31:0]     hi;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0] d_imm, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            d_we, d_ld, d_st, d_br, d_csr, d_ill, use1, use2;
  logic            hazard, enq, issue;

  assign hi    = buf_instr_q[head_q];
  assign opc   = hi[6:0];
  assign f3    = hi[14:12];
  assign f7    = hi[31:25];
  assign d_rd  = hi[11:7];
  assign d_rs1 = hi[19:15];
  assign d_rs2 = hi[24:20];
  assign imm_i = {{(XLEN-12){hi[31]}}, hi[31:20]};
  assign imm_s = {{(XLEN-12){hi[31]}}, hi[31:25], hi[11:7]};
  assign imm_b = {{(XLEN-13){hi[31]}}, hi[31], hi[7], hi[30:25], hi[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){hi[31]}}, hi[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};

  // Head decoder; illegal encodings never write, load, store or read sources.
  always_comb begin
    d_imm = '0; d_we = 1'b0; d_ld = 1'b0; d_st = 1'b0; d_br = 1'b0;
    d_csr = 1'b0; d_ill = 1'b0; use1 = 1'b0; use2 = 1'b0;
    case (opc)
      7'b0110111, 7'b0010111: begin d_we = 1'b1; d_imm = imm_u; end
      7'b1101111: begin d_we = 1'b1; d_imm = imm_j; end
      7'b1100111: begin d_we = 1'b1; d_imm = imm_i; use1 = 1'b1; d_ill = (f3 != 3'd0); end
      7'b1100011: begin
        d_br = 1'b1; d_imm = imm_b; use1 = 1'b1; use2 = 1'b1;
        d_ill = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'b0000011: begin d_ld = 1'b1; d_we = 1'b1; d_imm = imm_i; use1 = 1'b1; d_ill = (f3 == 3'd7); end
      7'b0100011: begin d_st = 1'b1; d_imm = imm_s; use1 = 1'b1; use2 = 1'b1; d_ill = f3[2]; end
      7'b0010011: begin
        d_we = 1'b1; use1 = 1'b1; d_imm = imm_i;
        if (f3 == 3'd1) begin
          d_imm = XLEN'(hi[25:20]); d_ill = (hi[31:26] != 6'b000000);
        end else if (f3 == 3'd5) begin
          d_imm = XLEN'(hi[25:20]);
          d_ill = (hi[31:26] != 6'b000000) && (hi[31:26] != 6'b010000);
        end
      end
      7'b0011011: begin
        d_we = 1'b1; use1 = 1'b1;
        case (f3)
          3'd0:    d_imm = imm_i;
          3'd1:    begin d_imm = XLEN'(hi[24:20]); d_ill = (f7 != 7'b0000000); end
          3'd5:    begin d_imm = XLEN'(hi[24:20]); d_ill = (f7 != 7'b0000000) && (f7 != 7'b0100000); end
          default: d_ill = 1'b1;
        endcase
      end
      7'b0110011: begin
        d_we = 1'b1; use1 = 1'b1; use2 = 1'b1;
        if (f7 == 7'b0100000)      d_ill = !((f3 == 3'd0) || (f3 == 3'd5));
        else if (f7 == 7'b0000001) d_ill = !MEXT_EN;
        else                       d_ill = (f7 != 7'b0000000);
      end
      7'b0111011: begin
        d_we = 1'b1; use1 = 1'b1; use2 = 1'b1;
        if (f7 == 7'b0000000)      d_ill = !((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5));
        else if (f7 == 7'b0100000) d_ill = !((f3 == 3'd0) || (f3 == 3'd5));
        else if (f7 == 7'b0000001) d_ill = !MEXT_EN || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3);
        else                       d_ill = 1'b1;
      end
      7'b1110011: begin
        case (f3)
          3'd0:                begin end
          3'd1, 3'd2, 3'd3:    begin d_csr = 1'b1; d_we = 1'b1; use1 = 1'b1; end
          3'd5, 3'd6, 3'd7:    begin d_csr = 1'b1; d_we = 1'b1; d_imm = XLEN'(hi[19:15]); end
          default:             d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_we = 1'b0; d_ld = 1'b0; d_st = 1'b0; use1 = 1'b0; use2 = 1'b0;
    end
  end

  assign hazard = (use1 && busy_q[d_rs1]) || (use2 && busy_q[d_rs2]) ||
                  (d_we && (d_rd != 5'd0) && busy_q[d_rd]);
  assign enq    = in_valid && in_ready_q && !flush;
  assign issue  = (count_q != '0) && !hazard && (!out_valid_q || out_ready) && !flush;

  // Next-state for pointers, occupancy, scoreboard and output valid.
  always_comb begin
    head_d      = issue ? head_q + PW'(1) : head_q;
    tail_d      = enq ? tail_q + PW'(1) : tail_q;
    count_d     = count_q + CW'(enq) - CW'(issue);
    out_valid_d = issue ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    if (flush) begin
      head_d = '0; tail_d = '0; count_d = '0; out_valid_d = 1'b0;
    end
    in_ready_d = (count_d != CW'(IBUF_DEPTH));
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (issue && d_we && (d_rd != 5'd0)) busy_d[d_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      buf_instr_q[tail_q] <= in_instr;
      buf_pc_q[tail_q]    <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0; tail_q <= '0; count_q <= '0; in_ready_q <= 1'b0; busy_q <= '0;
      out_valid_q <= 1'b0; out_pc_q <= '0; out_imm_q <= '0;
      out_rs1_q <= '0; out_rs2_q <= '0; out_rd_q <= '0;
      out_rf_we_q <= 1'b0; out_ld_q <= 1'b0; out_st_q <= 1'b0;
      out_br_q <= 1'b0; out_csr_q <= 1'b0; out_ill_q <= 1'b0;
    end else begin
      head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
      in_ready_q <= in_ready_d; busy_q <= busy_d; out_valid_q <= out_valid_d;
      if (issue) begin
        out_pc_q <= buf_pc_q[head_q]; out_imm_q <= d_imm;
        out_rs1_q <= d_rs1; out_rs2_q <= d_rs2; out_rd_q <= d_rd;
        out_rf_we_q <= d_we; out_ld_q <= d_ld; out_st_q <= d_st;
        out_br_q <= d_br; out_csr_q <= d_csr; out_ill_q <= d_ill;
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_imm       = out_imm_q;
  assign out_rs1       = out_rs1_q;
  assign out_rs2       = out_rs2_q;
  assign out_rd        = out_rd_q;
  assign out_rf_we     = out_rf_we_q;
  assign out_is_load   = out_ld_q;
  assign out_is_store  = out_st_q;
  assign out_is_branch = out_br_q;
  assign out_is_csr    = out_csr_q;
  assign out_illegal   = out_ill_q;
endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: decode vector table plus hazard, backpressure, flush and scoreboard sequences.
module tb_idu_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, wb_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, wb_rd;
  logic        out_rf_we, out_is_load, out_is_store, out_is_branch, out_is_csr, out_illegal;
  int          checks = 0;
  int          errors = 0;

  idu_stage #(.XLEN(64), .IBUF_DEPTH(4), .NREG(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_rf_we(out_rf_we), .out_is_load(out_is_load), .out_is_store(out_is_store),
    .out_is_branch(out_is_branch), .out_is_csr(out_is_csr), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        chk_imm;
    logic [5:0]  flags; // {rf_we, load, store, branch, csr, illegal}
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins);
    in_valid = 1'b1; in_instr = ins; step(); in_valid = 1'b0;
  endtask

  task automatic retire(input logic [4:0] rd);
    wb_valid = 1'b1; wb_rd = rd; step(); wb_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc;
    vecs[0]  = '{32'h00500093, 5'd1,  64'd5,                  1'b1, 6'b100000};
    vecs[1]  = '{32'h123452B7, 5'd5,  64'h0000000012345000,   1'b1, 6'b100000};
    vecs[2]  = '{32'h800002B7, 5'd5,  64'hFFFFFFFF80000000,   1'b1, 6'b100000};
    vecs[3]  = '{32'hFFF00113, 5'd2,  64'hFFFFFFFFFFFFFFFF,   1'b1, 6'b100000};
    vecs[4]  = '{32'h0080B183, 5'd3,  64'd8,                  1'b1, 6'b110000};
    vecs[5]  = '{32'hFE20BC23, 5'd24, 64'hFFFFFFFFFFFFFFF8,   1'b1, 6'b001000};
    vecs[6]  = '{32'hFE000EE3, 5'd29, 64'hFFFFFFFFFFFFFFFC,   1'b1, 6'b000100};
    vecs[7]  = '{32'h001000EF, 5'd1,  64'h800,                1'b1, 6'b100000};
    vecs[8]  = '{32'h03F09093, 5'd1,  64'd63,                 1'b1, 6'b100000};
    vecs[9]  = '{32'h4210D093, 5'd1,  64'd33,                 1'b1, 6'b100000};
    vecs[10] = '{32'h01F0909B, 5'd1,  64'd31,                 1'b1, 6'b100000};
    vecs[11] = '{32'h0200909B, 5'd1,  64'd0,                  1'b0, 6'b000001};
    vecs[12] = '{32'h3002D0F3, 5'd1,  64'd5,                  1'b1, 6'b100010};
    vecs[13] = '{32'h0000007F, 5'd0,  64'd0,                  1'b0, 6'b000001};
`ifdef IDU_MEXT_EN
    vecs[14] = '{32'h02208033, 5'd0,  64'd0,                  1'b0, 6'b100000};
`else
    vecs[14] = '{32'h02208033, 5'd0,  64'd0,                  1'b0, 6'b000001};
`endif
    vecs[15] = '{32'h42108133, 5'd2,  64'd0,                  1'b0, 6'b000001};
    vecs[16] = '{32'hFFFFF217, 5'd4,  64'hFFFFFFFFFFFFF000,   1'b1, 6'b100000};
    vecs[17] = '{32'h40208133, 5'd2,  64'd0,                  1'b0, 6'b100000};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_fields", {out_pc[31:0], out_imm[15:0], out_rd, out_rs1, out_rs2, 1'b0},
          64'd0);
    check("rst_flags", 64'({out_rf_we, out_is_load, out_is_store, out_is_branch, out_is_csr, out_illegal}), 64'd0);
    rst = 1'b0;
    check("in_ready_before_edge", 64'(in_ready), 64'd0);
    step();
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Decode table, one unhazarded instruction at a time.
    for (int i = 0; i < NV; i++) begin
      in_pc = 64'h80000000 + 64'(i * 4);
      push(vecs[i].instr);
      cyc = 0;
      while (!out_valid && cyc < 10) begin step(); cyc++; end
      check($sformatf("v%0d_latency", i), 64'(cyc), 64'd1);
      check($sformatf("v%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
      check($sformatf("v%0d_pc", i), out_pc, 64'h80000000 + 64'(i * 4));
      check($sformatf("v%0d_flags", i),
            64'({out_rf_we, out_is_load, out_is_store, out_is_branch, out_is_csr, out_illegal}),
            64'(vecs[i].flags));
      if (vecs[i].chk_imm) check($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      step();
      if (vecs[i].flags[5] && vecs[i].rd != 5'd0) retire(vecs[i].rd);
    end

    // RAW: add x2,x1,x1 waits for x1 writeback, issues the edge after the clear.
    in_valid = 1'b1; in_instr = 32'h00500093; step();
    in_instr = 32'h00108133; step(); in_valid = 1'b0;
    check("raw_first_rd", 64'(out_rd), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("raw_stall", 64'(out_valid), 64'd0);
    end
    retire(5'd1);
    check("raw_clear_edge", 64'(out_valid), 64'd0);
    step();
    check("raw_issue_valid", 64'(out_valid), 64'd1);
    check("raw_issue_rd", 64'(out_rd), 64'd2);
    step();
    retire(5'd2);

    // Backpressure: 5 pushes fill output register + 4 entries, then drain with wrap.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_ready", 64'(in_ready), 64'd1);
      push(32'((16 + k) << 20) | 32'h13);
    end
    check("bp_full", 64'(in_ready), 64'd0);
    check("bp_head_out", out_imm, 64'd16);
    in_valid = 1'b1; in_instr = 32'((99) << 20) | 32'h13;
    step(); step();
    in_valid = 1'b0;
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    check("bp_hold_imm", out_imm, 64'd16);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      check("bp_drain_valid", 64'(out_valid), 64'd1);
      check("bp_drain_imm", out_imm, 64'(16 + k));
    end
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush with a stalled output and 3 buffered entries; busy[5] must survive.
    out_ready = 1'b0;
    push(32'h00100293);
    for (int k = 0; k < 3; k++) push(32'((40 + k) << 20) | 32'h13);
    check("fl_pre_rd", 64'(out_rd), 64'd5);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'(77 << 20) | 32'h13;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step(); step();
    check("fl_empty", 64'(out_valid), 64'd0);
    push(32'h00028333);
    for (int k = 0; k < 3; k++) begin
      step();
      check("fl_busy_kept", 64'(out_valid), 64'd0);
    end
    retire(5'd5);
    step();
    check("fl_reader_rd", {63'd0, out_valid} << 5 | 64'(out_rd), 64'd38);
    step();
    retire(5'd6);

    // Same-cycle wb clear and issue-set of x3: set wins, reader of x3 stalls.
    push(32'h00700193);
    in_valid = 1'b1; in_instr = 32'h00018213; wb_valid = 1'b1; wb_rd = 5'd3;
    step();
    in_valid = 1'b0; wb_valid = 1'b0;
    check("sc_issue_rd", 64'(out_rd), 64'd3);
    for (int k = 0; k < 2; k++) begin
      step();
      check("sc_reader_stall", 64'(out_valid), 64'd0);
    end
    retire(5'd3);
    step();
    check("sc_reader_valid", 64'(out_valid), 64'd1);
    check("sc_reader_rd", 64'(out_rd), 64'd4);
    step();
    retire(5'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/idu_stage.md
Name: idu_stage

Overview:
- Registered instruction-decode stage for the RV64 core; the successor to the combinational decoder.
- Holds a parametrised instruction buffer, decodes the buffer head, and issues into a decoded-output register.
- Handshake is valid/ready on both sides.
- A register scoreboard stalls issue on RAW/WAW hazards against in-flight writes; pipeline flush is supported.
- Sits between the fetch unit and the execute unit.

Parameters:
- XLEN, 64, datapath width of pc and imm.
- IBUF_DEPTH, 4, instruction-buffer entries; power of two, >=2.
- NREG, 32, architectural integer registers tracked by the scoreboard.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  buffer can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction pc
- flush  in  1  discard all buffered and un-consumed decoded instructions
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  pc of issued instruction
- out_rs1, out_rs2, out_rd  out  5  register addresses
- out_imm  out  XLEN  extended immediate
- out_rf_we  out  1  writes rd
- out_is_load, out_is_store, out_is_branch, out_is_csr  out  1  class flags
- out_illegal  out  1  unsupported encoding
- wb_valid  in  1  a register write retires
- wb_rd  in  5  retiring destination

Behaviour:
- Reset (rst=1 at posedge):
  - Buffer empties, count=0; scoreboard all clear.
  - out_valid=0 and all out_* = 0; in_ready goes 1 the cycle after reset deasserts.
- Enqueue:
  - Occurs when in_valid && in_ready.
  - in_ready = (count != IBUF_DEPTH); there is no same-cycle dequeue credit.
  - Pointers wrap modulo IBUF_DEPTH.
- Issue from head:
  - Condition: count>0 && !hazard && (!out_valid || out_ready) && !flush.
  - The head is decoded combinationally and loaded into the output register; head pops.
- Latency: instruction handshaken at edge k is out_valid after edge k+1 when unhazarded (2 cycles).
- Output hold: while out_valid && !out_ready, all out_* are held stable. Back-to-back issue is allowed when out_ready=1, giving one instruction per cycle.
- Hazard:
  - A source counts as used only when its format reads it: rs1 for R/I/S/B/jalr/csr-register forms; rs2 for R/S/B.
  - Hazard is (rs1 used && busy[rs1]) || (rs2 used && busy[rs2]) || (rf_we && rd!=0 && busy[rd]).
  - x0 is never busy.
- Scoreboard:
  - Set busy[rd] on issue when rf_we && rd!=0 && !illegal.
  - Clear busy[wb_rd] on wb_valid.
  - Same-cycle set and clear of the same rd: set wins.
  - Hazard evaluation uses the registered scoreboard; there is no wb bypass, so a stalled instruction issues the cycle after the clear.
- Decode:
  - Supported: RV64I OP/OP-IMM/OP-32/OP-IMM-32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM.
  - Any other opcode, or an unmatched funct3/funct7 combination, sets out_illegal=1 and forces out_rf_we=out_is_load=out_is_store=0.
- Immediate formats:
  - I: 12-bit sign-extended.
  - S: 12-bit sign-extended.
  - B: 13-bit sign-extended, bit0=0.
  - U: imm[31:12]<<12, sign-extended to XLEN.
  - J: 21-bit sign-extended.
  - Shift shamt: 6-bit zero-extended; 5-bit for *W forms.
  - CSR immediate forms: zimm = instr[19:15] zero-extended.
- Store and branch: out_rf_we=0.
- flush:
  - Effective next edge: count=0, out_valid=0; no issue or enqueue that cycle.
  - Scoreboard is untouched, since older instructions still write back.
  - in_ready follows count as usual.
  - flush together with rst: rst dominates.

Optional Feature:
- Macro IDU_MEXT_EN.
- Defined: funct7=0000001 forms of OP (mul, mulh*, div, divu, rem, remu) and OP-32 (mulw, divw, divuw, remw, remuw) are legal, with out_rf_we=1.
- Undefined: those encodings decode as out_illegal=1 and never set the scoreboard.

Test Plan:
- Reset, then in_instr=0x00500093 (addi x1,x0,5), pc=0x80000000, out_ready=1 -> out_valid two cycles later: out_rd=1, out_imm=5, out_rf_we=1, busy[1]=1.
- Issue addi x1, then add x2,x1,x1 -> add stalls (out_valid=0) until wb_valid wb_rd=1; add issues on the following edge.
- out_ready=0, push 5 instructions, IBUF_DEPTH=4 -> first issues to the output register; in_ready drops after 4 more enqueues. Releasing out_ready drains in FIFO order including a pointer wrap.
- Stalled output with buffer holding 3 entries, flush=1 -> next cycle out_valid=0, count=0; busy bits unchanged.
- in_instr=0x02208033 (mul x0,x1,x2) -> with IDU_MEXT_EN defined: out_illegal=0, rf_we=1, busy untouched because rd=0. Without the macro: out_illegal=1, out_rf_we=0.
- Same-cycle wb_valid wb_rd=3 and issue of addi x3 -> busy[3]=1 afterwards; a following reader of x3 stalls.
